mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DEPTH, 32, number of 64-bit doublewords in data memory; power of two, 8 to 256.
REQ-002 Parameter WAIT_CYCLES, 2, added access latency in cycles, 0 to 7.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ex_mem_adderout  in  64  branch target.
REQ-006 ex_mem_zero  in  1  branch condition.
REQ-007 ex_mem_result  in  64  ALU result: byte address for loads/stores, writeback value otherwise.
REQ-008 ex_mem_writedata  in  64  store data.
REQ-009 ex_mem_rd  in  5  destination register.
REQ-010 ex_mem_branch, ex_mem_memread, ex_mem_memtoreg, ex_mem_memwrite, ex_mem_regwrite  in  1 each  control bits.
REQ-011 pcsrc  out  1  taken-branch select.
REQ-012 branch_target  out  64  redirect PC.
REQ-013 mem_stall  out  1  freeze upstream stages.
REQ-014 mem_wb_readdata, mem_wb_result  out  64 each  registered load data, registered ALU result.
REQ-015 mem_wb_rd  out  5; mem_wb_memtoreg, mem_wb_regwrite, mem_wb_fault  out  1 each; all registered.

Function
REQ-016 pcsrc SHALL be ex_mem_branch AND ex_mem_zero, combinational; branch_target SHALL equal ex_mem_adderout.
REQ-017 An access SHALL be any cycle with ex_mem_memread or ex_mem_memwrite high.
REQ-018 FSM states SHALL be IDLE and BUSY, with a 3-bit down-counter cnt.
REQ-019 IDLE, access, WAIT_CYCLES>0: mem_stall=1; next state BUSY; cnt loads WAIT_CYCLES-1.
REQ-020 BUSY, cnt!=0: mem_stall=1; cnt decrements.
REQ-021 BUSY, cnt==0: mem_stall=0; access completes this edge; next state IDLE.
REQ-022 IDLE, access, WAIT_CYCLES==0: access SHALL complete in the same cycle with mem_stall=0.
REQ-023 Total access time SHALL be WAIT_CYCLES+1 cycles; mem_stall high for exactly WAIT_CYCLES consecutive cycles.
REQ-024 Non-access cycles SHALL never stall and SHALL complete in one cycle.
REQ-025 Upstream SHALL hold all ex_mem_* inputs stable while mem_stall=1; the block does not latch them.
REQ-026 Word index SHALL be ex_mem_result[log2(DEPTH)+2:3].
REQ-027 An access SHALL fault when ex_mem_result[2:0]!=0 or ex_mem_result>=8*DEPTH.
REQ-028 Faulting stores SHALL not modify memory.
REQ-029 Faulting loads SHALL return 0.
REQ-030 On a faulting access, mem_wb_fault SHALL be 1 for the one completing cycle.
REQ-031 Non-faulting stores SHALL write the full 64 bits only on the completing edge, never on stall edges.
REQ-032 Loads SHALL capture the array word into mem_wb_readdata on the completing edge.
REQ-033 When memread and memwrite are both high, the load SHALL return pre-write contents and the store SHALL still occur.
REQ-034 On a completing edge, the MEM/WB register SHALL load result, rd, memtoreg and regwrite from the inputs.
REQ-035 On every stall edge, the MEM/WB register SHALL load a bubble: regwrite=0, memtoreg=0, fault=0, rd=0; data fields unchanged.
REQ-036 On non-load completions, mem_wb_readdata SHALL be 0.

Reset
REQ-037 While reset=1 at a rising edge, state SHALL go to IDLE and cnt to 0.
REQ-038 While reset=1 at a rising edge, all mem_wb_* outputs SHALL go to 0.
REQ-039 While reset=1, mem_stall SHALL be forced to 0.
REQ-040 Reset during BUSY SHALL abort the access; no memory write occurs.
REQ-041 Memory array contents SHALL be unaffected by reset.
REQ-042 Reset SHALL take priority over every other event at the same edge.

Verification
REQ-043 WAIT_CYCLES=2: store 0xDEAD_BEEF_0000_0001 to address 0x10 -> mem_stall high 2 cycles, write on 3rd edge; load 0x10 -> mem_wb_readdata=0xDEAD_BEEF_0000_0001 after 3 cycles, mem_wb_regwrite=1 only then.
REQ-044 ALU op: result=0x55, rd=7, regwrite=1, no access -> next edge mem_wb_result=0x55, mem_wb_rd=7, no stall.
REQ-045 Branch: branch=1, zero=1, adderout=0x400 -> pcsrc=1, branch_target=0x400 same cycle; zero=0 -> pcsrc=0.
REQ-046 Load at 0x13 (misaligned) and at 8*DEPTH -> mem_wb_readdata=0, mem_wb_fault=1 one cycle; store to 0x13 leaves memory unchanged.
REQ-047 Store 0xAA to address 0x08 with reset asserted during the second BUSY cycle -> outputs 0, state IDLE, subsequent load 0x08 returns prior contents.
REQ-048 WAIT_CYCLES=0: back-to-back store/load to address 0x20 -> mem_stall never high, load returns stored value next edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory-access stage plus MEM/WB pipeline register for a 64-bit pipeline.
// Owns a small doubleword data memory with a configurable access latency.
// While an access waits, the stage stalls upstream and feeds bubbles into
// the MEM/WB register.
//
// Parameters
//   DEPTH       : number of 64-bit doublewords in the data memory (pow2, 8..256)
//   WAIT_CYCLES : extra access latency in cycles (0..7)
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   ex_mem_adderout           : branch target from EX
//   ex_mem_zero               : branch condition from EX
//   ex_mem_result             : ALU result (byte address for loads/stores)
//   ex_mem_writedata          : store data
//   ex_mem_rd                 : destination register
//   ex_mem_branch/memread/memtoreg/memwrite/regwrite : control bits
//   pcsrc, branch_target      : combinational branch redirect
//   mem_stall                 : combinational freeze request to upstream stages
//   mem_wb_*                  : registered MEM/WB pipeline outputs
// ---------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] ex_mem_adderout,
   input  logic        ex_mem_zero,
   input  logic [63:0] ex_mem_result,
   input  logic [63:0] ex_mem_writedata,
   input  logic [4:0]  ex_mem_rd,
   input  logic        ex_mem_branch,
   input  logic        ex_mem_memread,
   input  logic        ex_mem_memtoreg,
   input  logic        ex_mem_memwrite,
   input  logic        ex_mem_regwrite,
   output logic        pcsrc,
   output logic [63:0] branch_target,
   output logic        mem_stall,
   output logic [63:0] mem_wb_readdata,
   output logic [63:0] mem_wb_result,
   output logic [4:0]  mem_wb_rd,
   output logic        mem_wb_memtoreg,
   output logic        mem_wb_regwrite,
   output logic        mem_wb_fault
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam logic [63:0] MEM_BYTES = 64'(8 * DEPTH);
   // First BUSY cycle starts one below WAIT_CYCLES: the IDLE cycle already stalled once.
   localparam logic [2:0]  CNT_INIT  = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic [2:0]    cnt;
   logic [2:0]    cnt_nxt;
   logic          access_c;
   logic          misaddr_c;
   logic          fault_c;
   logic          stall_c;
   logic          complete_c;
   logic [AW-1:0] idx_c;

   logic [63:0]   mem [DEPTH];

   // Branch resolution is purely combinational
   assign pcsrc         = ex_mem_branch & ex_mem_zero;
   assign branch_target = ex_mem_adderout;

   // Address decode and fault detection
   assign access_c  = ex_mem_memread | ex_mem_memwrite;
   assign misaddr_c = (ex_mem_result[2:0] != 3'd0) || (ex_mem_result >= MEM_BYTES);
   assign fault_c   = access_c & misaddr_c;
   assign idx_c     = ex_mem_result[AW+2:3];

   // Next-state / stall logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_c   = 1'b0;
      case (state)
         IDLE: begin
            if (access_c && (WAIT_CYCLES != 0)) begin
               stall_c   = 1'b1;
               state_nxt = BUSY;
               cnt_nxt   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt != 3'd0) begin
               stall_c = 1'b1;
               cnt_nxt = cnt - 3'd1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   // Any non-stall cycle retires whatever is presented this cycle
   assign complete_c = ~stall_c;
   assign mem_stall  = ~reset & stall_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Data array: no reset, written only on a clean completing store
   always_ff @(posedge clk) begin
      if (!reset && complete_c && ex_mem_memwrite && !fault_c) begin
         mem[idx_c] <= ex_mem_writedata;
      end
   end

   // MEM/WB pipeline register; stall edges insert a bubble and keep data fields
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_wb_readdata <= 64'd0;
         mem_wb_result   <= 64'd0;
         mem_wb_rd       <= 5'd0;
         mem_wb_memtoreg <= 1'b0;
         mem_wb_regwrite <= 1'b0;
         mem_wb_fault    <= 1'b0;
      end else if (stall_c) begin
         mem_wb_rd       <= 5'd0;
         mem_wb_memtoreg <= 1'b0;
         mem_wb_regwrite <= 1'b0;
         mem_wb_fault    <= 1'b0;
      end else begin
         // Read sees the pre-write word when a store hits the same edge
         mem_wb_readdata <= (ex_mem_memread && !fault_c) ? mem[idx_c] : 64'd0;
         mem_wb_result   <= ex_mem_result;
         mem_wb_rd       <= ex_mem_rd;
         mem_wb_memtoreg <= ex_mem_memtoreg;
         mem_wb_regwrite <= ex_mem_regwrite;
         mem_wb_fault    <= fault_c;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed bench for mem_wb_stage: one instance with WAIT_CYCLES=2 (main)
// and one with WAIT_CYCLES=0 (prefix z_). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

   logic        clk;
   logic        reset;

   logic [63:0] adderout, result, writedata;
   logic        zero, branch, memread, memtoreg, memwrite, regwrite;
   logic [4:0]  rd;
   logic        pcsrc, mem_stall;
   logic [63:0] branch_target, wb_readdata, wb_result;
   logic [4:0]  wb_rd;
   logic        wb_memtoreg, wb_regwrite, wb_fault;

   logic [63:0] z_result, z_writedata;
   logic        z_memread, z_memwrite, z_regwrite;
   logic [4:0]  z_rd;
   logic        z_pcsrc, z_mem_stall;
   logic [63:0] z_branch_target, z_wb_readdata, z_wb_result;
   logic [4:0]  z_wb_rd;
   logic        z_wb_memtoreg, z_wb_regwrite, z_wb_fault;

   int checks   = 0;
   int failures = 0;
   int stalls;

   mem_wb_stage #(.DEPTH(32), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .ex_mem_adderout(adderout), .ex_mem_zero(zero), .ex_mem_result(result),
      .ex_mem_writedata(writedata), .ex_mem_rd(rd), .ex_mem_branch(branch),
      .ex_mem_memread(memread), .ex_mem_memtoreg(memtoreg),
      .ex_mem_memwrite(memwrite), .ex_mem_regwrite(regwrite),
      .pcsrc(pcsrc), .branch_target(branch_target), .mem_stall(mem_stall),
      .mem_wb_readdata(wb_readdata), .mem_wb_result(wb_result), .mem_wb_rd(wb_rd),
      .mem_wb_memtoreg(wb_memtoreg), .mem_wb_regwrite(wb_regwrite),
      .mem_wb_fault(wb_fault)
   );

   mem_wb_stage #(.DEPTH(32), .WAIT_CYCLES(0)) dut_z (
      .clk(clk), .reset(reset),
      .ex_mem_adderout(64'd0), .ex_mem_zero(1'b0), .ex_mem_result(z_result),
      .ex_mem_writedata(z_writedata), .ex_mem_rd(z_rd), .ex_mem_branch(1'b0),
      .ex_mem_memread(z_memread), .ex_mem_memtoreg(1'b0),
      .ex_mem_memwrite(z_memwrite), .ex_mem_regwrite(z_regwrite),
      .pcsrc(z_pcsrc), .branch_target(z_branch_target), .mem_stall(z_mem_stall),
      .mem_wb_readdata(z_wb_readdata), .mem_wb_result(z_wb_result), .mem_wb_rd(z_wb_rd),
      .mem_wb_memtoreg(z_wb_memtoreg), .mem_wb_regwrite(z_wb_regwrite),
      .mem_wb_fault(z_wb_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      adderout = '0; result = '0; writedata = '0; rd = '0;
      zero = 0; branch = 0; memread = 0; memtoreg = 0; memwrite = 0; regwrite = 0;
   endtask

   // Present one access, hold it through the stall, retire it on the completing edge
   task automatic run_access(input logic rden, input logic wren, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [4:0] dst,
                             input logic rw, output int n_stall);
      idle_inputs();
      memread = rden; memwrite = wren; result = addr; writedata = wd;
      rd = dst; regwrite = rw; memtoreg = rden;
      #1;
      n_stall = 0;
      while (mem_stall === 1'b1 && n_stall < 20) begin
         n_stall++;
         tick();
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      z_result = '0; z_writedata = '0; z_rd = '0;
      z_memread = 0; z_memwrite = 0; z_regwrite = 0;
      reset = 1'b1;
      memread = 1'b1;
      #1;
      chk("stall_forced_in_reset", 64'(mem_stall), 64'd0);
      tick(); tick();
      chk("rst_readdata", wb_readdata, 64'd0);
      chk("rst_result", wb_result, 64'd0);
      chk("rst_rd", 64'(wb_rd), 64'd0);
      chk("rst_regwrite", 64'(wb_regwrite), 64'd0);
      chk("rst_fault", 64'(wb_fault), 64'd0);
      reset = 1'b0;
      idle_inputs();
      #1;

      // ALU-only op
      result = 64'h55; rd = 5'd7; regwrite = 1'b1;
      #1;
      chk("alu_no_stall", 64'(mem_stall), 64'd0);
      tick();
      chk("alu_result", wb_result, 64'h55);
      chk("alu_rd", 64'(wb_rd), 64'd7);
      chk("alu_regwrite", 64'(wb_regwrite), 64'd1);
      idle_inputs();

      // Branch
      branch = 1'b1; zero = 1'b1; adderout = 64'h400;
      #1;
      chk("br_pcsrc_taken", 64'(pcsrc), 64'd1);
      chk("br_target", branch_target, 64'h400);
      zero = 1'b0;
      #1;
      chk("br_pcsrc_not_taken", 64'(pcsrc), 64'd0);
      idle_inputs();

      // Store 0x10 with explicit stall/bubble checks
      memwrite = 1'b1; result = 64'h10; writedata = 64'hDEAD_BEEF_0000_0001;
      #1;
      chk("st_stall_c0", 64'(mem_stall), 64'd1);
      tick();
      chk("st_stall_c1", 64'(mem_stall), 64'd1);
      chk("st_bubble_regwrite", 64'(wb_regwrite), 64'd0);
      chk("st_bubble_rd", 64'(wb_rd), 64'd0);
      chk("st_bubble_result_held", wb_result, 64'h55);
      tick();
      chk("st_stall_c2", 64'(mem_stall), 64'd0);
      tick();

      // Load 0x10
      idle_inputs();
      memread = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; rd = 5'd5; result = 64'h10;
      #1;
      chk("ld_stall_c0", 64'(mem_stall), 64'd1);
      tick();
      chk("ld_bubble1_regwrite", 64'(wb_regwrite), 64'd0);
      tick();
      chk("ld_bubble2_regwrite", 64'(wb_regwrite), 64'd0);
      chk("ld_stall_c2", 64'(mem_stall), 64'd0);
      tick();
      chk("ld_readdata", wb_readdata, 64'hDEAD_BEEF_0000_0001);
      chk("ld_regwrite", 64'(wb_regwrite), 64'd1);
      chk("ld_rd", 64'(wb_rd), 64'd5);
      chk("ld_memtoreg", 64'(wb_memtoreg), 64'd1);
      chk("ld_fault", 64'(wb_fault), 64'd0);
      idle_inputs();
      tick();
      chk("nonload_readdata_zero", wb_readdata, 64'd0);

      // Simultaneous read+write returns old data, store still lands
      run_access(1'b0, 1'b1, 64'h18, 64'hA5A5_0000_1111_2222, 5'd0, 1'b0, stalls);
      chk("st18_stalls", 64'(stalls), 64'd2);
      run_access(1'b1, 1'b1, 64'h18, 64'h0BAD_F00D_CAFE_0042, 5'd2, 1'b1, stalls);
      chk("rw18_old_data", wb_readdata, 64'hA5A5_0000_1111_2222);
      run_access(1'b1, 1'b0, 64'h18, 64'd0, 5'd2, 1'b1, stalls);
      chk("rw18_new_data", wb_readdata, 64'h0BAD_F00D_CAFE_0042);

      // Faults
      run_access(1'b1, 1'b0, 64'h13, 64'd0, 5'd4, 1'b1, stalls);
      chk("mis_ld_stalls", 64'(stalls), 64'd2);
      chk("mis_ld_readdata", wb_readdata, 64'd0);
      chk("mis_ld_fault", 64'(wb_fault), 64'd1);
      tick();
      chk("mis_ld_fault_one_cycle", 64'(wb_fault), 64'd0);
      run_access(1'b1, 1'b0, 64'h100, 64'd0, 5'd4, 1'b1, stalls);
      chk("oob_ld_readdata", wb_readdata, 64'd0);
      chk("oob_ld_fault", 64'(wb_fault), 64'd1);
      run_access(1'b0, 1'b1, 64'h13, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 1'b0, stalls);
      chk("mis_st_fault", 64'(wb_fault), 64'd1);
      run_access(1'b1, 1'b0, 64'h10, 64'd0, 5'd6, 1'b1, stalls);
      chk("mis_st_mem_unchanged", wb_readdata, 64'hDEAD_BEEF_0000_0001);
      chk("clean_ld_fault", 64'(wb_fault), 64'd0);

      // Reset in the second BUSY cycle aborts the store
      run_access(1'b0, 1'b1, 64'h08, 64'h1111_2222_3333_4444, 5'd0, 1'b0, stalls);
      memwrite = 1'b1; result = 64'h08; writedata = 64'hAA; regwrite = 1'b1; rd = 5'd9;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rst_busy_stall_forced", 64'(mem_stall), 64'd0);
      tick();
      chk("rst_busy_result", wb_result, 64'd0);
      chk("rst_busy_regwrite", 64'(wb_regwrite), 64'd0);
      chk("rst_busy_readdata", wb_readdata, 64'd0);
      reset = 1'b0;
      run_access(1'b1, 1'b0, 64'h08, 64'd0, 5'd1, 1'b1, stalls);
      chk("rst_busy_idle_after", 64'(stalls), 64'd2);
      chk("rst_busy_mem_prior", wb_readdata, 64'h1111_2222_3333_4444);

      // Zero-wait instance: back-to-back store/load
      z_memwrite = 1'b1; z_result = 64'h20; z_writedata = 64'h1234_5678_9ABC_DEF0;
      #1;
      chk("z_st_no_stall", 64'(z_mem_stall), 64'd0);
      tick();
      z_memwrite = 1'b0; z_memread = 1'b1; z_regwrite = 1'b1; z_rd = 5'd3;
      #1;
      chk("z_ld_no_stall", 64'(z_mem_stall), 64'd0);
      tick();
      chk("z_ld_readdata", z_wb_readdata, 64'h1234_5678_9ABC_DEF0);
      chk("z_ld_regwrite", 64'(z_wb_regwrite), 64'd1);
      chk("z_ld_rd", 64'(z_wb_rd), 64'd3);
      z_memread = 1'b0; z_regwrite = 1'b0; z_rd = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
